// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared encodings and default sizes for the count_seq_ctrl block.
//   op_e      - command opcodes carried on cmd_op
//   state_e   - sequencer state encoding
//   *_DEF     - default parameter values
package count_seq_pkg;

   localparam int WIDTH_DEF     = 4;
   localparam int ROUNDS_W_DEF  = 4;
   localparam int PRESC_DIV_DEF = 4;

   typedef enum logic [1:0] {
      OP_START  = 2'd0,
      OP_STOP   = 2'd1,
      OP_PAUSE  = 2'd2,
      OP_RESUME = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      RUN  = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4
   } state_e;

endpackage

// File: rtl/hex_step_counter.sv
// hex_step_counter: WIDTH-bit up-counter with parallel load and step enable.
//   clk      - clock, rising edge
//   res      - synchronous active-low reset (q -> 0)
//   load     - load load_val (has priority over en)
//   load_val - value loaded when load=1
//   en       - increment q modulo 2^WIDTH
//   q        - counter value
module hex_step_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!res)      q <= '0;
      else if (load) q <= load_val;
      else if (en)   q <= q + WIDTH'(1);
   end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: command-driven sequencer for a hex up-counter. Runs the
// counter from a start value to an end value for a number of rounds
// (0 = until STOP) and pulses done on normal completion.
//   clk, res              - clock / synchronous active-low reset
//   cmd_valid, cmd_ready  - command handshake
//   cmd_op                - START / STOP / PAUSE / RESUME
//   cmd_start, cmd_end    - count range, sampled on START
//   cmd_rounds            - rounds to run, sampled on START
//   q, round_cnt          - counter value, completed rounds
//   busy, done, err       - activity, completion pulse, illegal-command pulse
// Optional macro SEQ_PRESCALE_EN: steps only every PRESC_DIV RUN cycles.
//
// state | meaning
// IDLE  | waiting for START; q/round_cnt hold last run's values
// ARM   | one cycle; loads start value into the counter
// RUN   | counting; terminal compare at q == end
// HOLD  | paused; q (and prescaler) frozen
// DONE  | one cycle; done pulse, then IDLE
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int ROUNDS_W  = ROUNDS_W_DEF,
   parameter int PRESC_DIV = PRESC_DIV_DEF
) (
   input  logic                clk,
   input  logic                res,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [WIDTH-1:0]    cmd_start,
   input  logic [WIDTH-1:0]    cmd_end,
   input  logic [ROUNDS_W-1:0] cmd_rounds,
   output logic [WIDTH-1:0]    q,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ROUNDS_W-1:0] round_cnt
);

   if (PRESC_DIV < 1 || PRESC_DIV > 255) begin : g_presc_range
      $error("count_seq_ctrl: PRESC_DIV must be 1..255");
   end

   state_e              state, state_nxt;
   logic [WIDTH-1:0]    start_r, end_r;
   logic [ROUNDS_W-1:0] rounds_r, rc_nxt, rc_inc;
   logic                accept, step, ld, en, err_nxt, done_nxt, latch;
   op_e                 op;

   assign op     = op_e'(cmd_op);
   assign accept = cmd_valid & cmd_ready;
   assign rc_inc = round_cnt + ROUNDS_W'(1);

`ifdef SEQ_PRESCALE_EN
   localparam logic [7:0] PSC_LAST = 8'(PRESC_DIV - 1);
   logic [7:0] psc;

   assign step = (state == RUN) && (psc == PSC_LAST);

   // Only advances in RUN, so a PAUSE/RESUME pair continues the same phase.
   always_ff @(posedge clk) begin
      if (!res)               psc <= '0;
      else if (state == ARM)  psc <= '0;
      else if (state == RUN)  psc <= step ? 8'd0 : psc + 8'd1;
   end
`else
   assign step = (state == RUN);
`endif

   always_comb begin
      state_nxt = state;
      rc_nxt    = round_cnt;
      ld        = 1'b0;
      en        = 1'b0;
      err_nxt   = 1'b0;
      done_nxt  = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (op == OP_START) begin
                  latch     = 1'b1;
                  rc_nxt    = '0;
                  state_nxt = ARM;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         ARM: begin
            ld        = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            if (accept && op == OP_STOP) begin
               state_nxt = IDLE;
            end else begin
               if (accept && (op == OP_START || op == OP_RESUME)) err_nxt = 1'b1;
               if (accept && op == OP_PAUSE) state_nxt = HOLD;
               if (step) begin
                  if (q == end_r) begin
                     // Final round overrides a same-cycle PAUSE.
                     if (rounds_r != '0 && rc_inc == rounds_r) begin
                        rc_nxt    = rounds_r;
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                     end else begin
                        rc_nxt = rc_inc;
                        ld     = 1'b1;
                     end
                  end else begin
                     en = 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (accept) begin
               case (op)
                  OP_RESUME: state_nxt = RUN;
                  OP_STOP:   state_nxt = IDLE;
                  default:   err_nxt   = 1'b1;
               endcase
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state     <= IDLE;
         round_cnt <= '0;
         start_r   <= '0;
         end_r     <= '0;
         rounds_r  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_nxt;
         round_cnt <= rc_nxt;
         if (latch) begin
            start_r  <= cmd_start;
            end_r    <= cmd_end;
            rounds_r <= cmd_rounds;
         end
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
         err       <= err_nxt;
         cmd_ready <= (state_nxt == IDLE) || (state_nxt == RUN) || (state_nxt == HOLD);
      end
   end

   hex_step_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .res      (res),
      .load     (ld),
      .load_val (start_r),
      .en       (en),
      .q        (q)
   );

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed scoreboard bench for count_seq_ctrl.
// Expected per-cycle outputs are queued as stimulus is driven and compared
// one entry per clock, #1 after the rising edge.
module tb_count_seq_ctrl;

`ifdef SEQ_PRESCALE_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_start = 4'd0, cmd_end = 4'd0, cmd_rounds = 4'd0;
   logic [3:0] q, round_cnt;
   logic       busy, done, err;

   typedef struct {
      logic [3:0] q;
      logic [3:0] rc;
      logic       busy, done, err, ready;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   count_seq_ctrl dut (
      .clk        (clk),
      .res        (res),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_start  (cmd_start),
      .cmd_end    (cmd_end),
      .cmd_rounds (cmd_rounds),
      .q          (q),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .round_cnt  (round_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, expv);
      end
   endtask

   task automatic push(input logic [3:0] eq, input logic [3:0] erc, input logic eb,
                       input logic ed, input logic ee, input logic er);
      exp_t e;
      e.q = eq; e.rc = erc; e.busy = eb; e.done = ed; e.err = ee; e.ready = er;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("q",         q,           e.q);
         chk("round_cnt", round_cnt,   e.rc);
         chk("busy",      4'(busy),      4'(e.busy));
         chk("done",      4'(done),      4'(e.done));
         chk("err",       4'(err),       4'(e.err));
         chk("cmd_ready", 4'(cmd_ready), 4'(e.ready));
      end
   endtask

   task automatic drain();
      while (sb.size() != 0) cycle();
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [3:0] s,
                            input logic [3:0] e, input logic [3:0] r);
      cmd_valid = 1'b1; cmd_op = op; cmd_start = s; cmd_end = e; cmd_rounds = r;
   endtask

   // Whole expected trace of an uninterrupted run, from the ARM cycle to IDLE.
   task automatic push_run(input logic [3:0] s, input logic [3:0] e,
                           input int r, input logic [3:0] qprev);
      logic [3:0] v;
      push(qprev, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int rr = 0; rr < r; rr++) begin
         v = s;
         for (int k = 0; k < 16; k++) begin
            for (int d = 0; d < DIV; d++) push(v, 4'(rr), 1'b1, 1'b0, 1'b0, 1'b1);
            if (v == e) break;
            v = v + 4'd1;
         end
      end
      push(e, 4'(r), 1'b1, 1'b1, 1'b0, 1'b0);
      push(e, 4'(r), 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [3:0] qp;

      // reset
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(); cycle();
      res = 1'b1;
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();

      // single round 2..5
      drive_cmd(2'd0, 4'd2, 4'd5, 4'd1);
      push_run(4'd2, 4'd5, 1, 4'd0);
      cycle();
      cmd_valid = 1'b0;
      drain();

      // wrap 14..1, two rounds
      drive_cmd(2'd0, 4'd14, 4'd1, 4'd2);
      push_run(4'd14, 4'd1, 2, 4'd5);
      cycle();
      cmd_valid = 1'b0;
      drain();

`ifndef SEQ_PRESCALE_EN
      // PAUSE at q=3 (step still taken), hold, RESUME
      drive_cmd(2'd0, 4'd0, 4'd9, 4'd1);
      push(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      for (int v = 0; v <= 3; v++) begin
         push(4'(v), 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
         cycle();
      end
      drive_cmd(2'd2, 4'd0, 4'd0, 4'd0);
      push(4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push(4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
         cycle();
      end
      drive_cmd(2'd3, 4'd0, 4'd0, 4'd0);
      push(4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      for (int v = 5; v <= 9; v++) push(4'(v), 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(4'd9, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      push(4'd9, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      // infinite rounds 0..3, STOP on a terminal cycle
      drive_cmd(2'd0, 4'd0, 4'd3, 4'd0);
      push(4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      for (int k = 0; k < 24; k++) begin
         push(4'(k % 4), 4'(k / 4), 1'b1, 1'b0, 1'b0, 1'b1);
         cycle();
      end
      drive_cmd(2'd1, 4'd0, 4'd0, 4'd0);
      push(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      push(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      push(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      // PAUSE in IDLE -> err, nothing else changes
      drive_cmd(2'd2, 4'd0, 4'd0, 4'd0);
      push(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      push(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();

      // START while RUN -> err, new operands ignored
      drive_cmd(2'd0, 4'd5, 4'd8, 4'd1);
      push(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      push(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      drive_cmd(2'd0, 4'd0, 4'd2, 4'd3);
      push(4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      push(4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(4'd8, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      push(4'd8, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();
      qp = 4'd8;
`else
      qp = 4'd1;
`endif

      // reset in the middle of a run at q=7
      drive_cmd(2'd0, 4'd4, 4'd12, 4'd0);
      push(qp, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      for (int v = 4; v <= 7; v++) begin
         for (int d = 0; d < DIV; d++) begin
            push(4'(v), 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            cycle();
         end
      end
      res = 1'b0;
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      res = 1'b1;
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      push(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
